// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the four-port SRAM arbiter.
// Priority order is VGA > UART > M1 > M2.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    S_ARB_IDLE = 2'd0,
    S_ARB_OWN  = 2'd1,
    S_ARB_TURN = 2'd2
  } arb_state_type;

  localparam logic [1:0] ARB_UART = 2'd0;
  localparam logic [1:0] ARB_M1   = 2'd1;
  localparam logic [1:0] ARB_M2   = 2'd2;
  localparam logic [1:0] ARB_VGA  = 2'd3;

  localparam logic [15:0] ARB_MAX_HOLD_DEFAULT = 16'd1024;

  // One-hot winner of a request vector, or zero when nothing is requested.
  function automatic logic [3:0] arb_pick(input logic [3:0] req);
    logic [3:0] grant;
    grant = '0;
    if (req[ARB_VGA]) begin
      grant[ARB_VGA] = 1'b1;
    end else if (req[ARB_UART]) begin
      grant[ARB_UART] = 1'b1;
    end else if (req[ARB_M1]) begin
      grant[ARB_M1] = 1'b1;
    end else if (req[ARB_M2]) begin
      grant[ARB_M2] = 1'b1;
    end
    return grant;
  endfunction

  function automatic logic [1:0] arb_index(input logic [3:0] grant);
    logic [1:0] idx;
    idx = ARB_UART;
    if (grant[ARB_VGA]) begin
      idx = ARB_VGA;
    end else if (grant[ARB_M1]) begin
      idx = ARB_M1;
    end else if (grant[ARB_M2]) begin
      idx = ARB_M2;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sram_read_tag_pipe.sv
// Delay line carrying the requester tag of each issued read so the matching
// Read_valid bit fires READ_LATENCY cycles after the read was issued.
module sram_read_tag_pipe #(
  parameter int unsigned READ_LATENCY = 3
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       i_push_valid,
  input  logic [1:0] i_push_tag,
  output logic [3:0] o_read_valid,
  output logic       o_busy
);

  logic [READ_LATENCY-1:0]      r_valid;
  logic [READ_LATENCY-1:0][1:0] r_tag;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_valid <= '0;
      r_tag   <= '0;
    end else begin
      r_valid[0] <= i_push_valid;
      r_tag[0]   <= i_push_tag;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  always_comb begin
    o_read_valid = '0;
    if (r_valid[READ_LATENCY-1]) begin
      o_read_valid[r_tag[READ_LATENCY-1]] = 1'b1;
    end
  end

  assign o_busy = |r_valid;

endmodule

// File: rtl/sram_arbiter.sv
// Four-requester SRAM arbiter: fixed priority, owner holds until release or a
// hold-limit forced release, one idle turnaround cycle between owners.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 3,
  parameter logic [15:0] MAX_HOLD     = ARB_MAX_HOLD_DEFAULT
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic [3:0]      Req,
  input  logic [3:0][17:0] Req_address,
  input  logic [3:0][15:0] Req_write_data,
  input  logic [3:0]      Req_we_n,
  output logic [3:0]      Grant,
  output logic [3:0]      Read_valid,
  output logic [17:0]     SRAM_address,
  output logic [15:0]     SRAM_write_data,
  output logic            SRAM_we_n,
  output logic            Busy
);

  localparam logic [15:0] HOLD_LAST = MAX_HOLD - 16'd1;

  arb_state_type r_state, w_state_next;
  logic [3:0]    r_grant, w_grant_next;
  logic [15:0]   r_hold_cnt, w_hold_cnt_next;
  logic [1:0]    w_owner;
  logic          w_others_req;
  logic          w_push_valid;
  logic          w_pipe_busy;

  assign w_owner      = arb_index(r_grant);
  assign w_others_req = |(Req & ~r_grant);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= S_ARB_IDLE;
      r_grant    <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_hold_cnt <= w_hold_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_hold_cnt_next = r_hold_cnt;
    unique case (r_state)
      S_ARB_IDLE: begin
        if (|Req) begin
          w_grant_next    = arb_pick(Req);
          w_hold_cnt_next = '0;
          w_state_next    = S_ARB_OWN;
        end
      end
      S_ARB_OWN: begin
        if (!Req[w_owner] || ((r_hold_cnt == HOLD_LAST) && w_others_req)) begin
          w_grant_next = '0;
          w_state_next = S_ARB_TURN;
        end else if (r_hold_cnt != HOLD_LAST) begin
          w_hold_cnt_next = r_hold_cnt + 16'd1;
        end
      end
      S_ARB_TURN: begin
        // A force-released owner still requesting competes here like anyone else.
        if (|Req) begin
          w_grant_next    = arb_pick(Req);
          w_hold_cnt_next = '0;
          w_state_next    = S_ARB_OWN;
        end else begin
          w_grant_next = '0;
          w_state_next = S_ARB_IDLE;
        end
      end
      default: begin
        w_grant_next = '0;
        w_state_next = S_ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    if (|r_grant) begin
      SRAM_address    = Req_address[w_owner];
      SRAM_write_data = Req_write_data[w_owner];
      SRAM_we_n       = Req_we_n[w_owner];
    end
  end

  // Reads are tagged on the granted cycle even if the owner is releasing.
  assign w_push_valid = (|r_grant) & Req_we_n[w_owner];

  sram_read_tag_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_tag_pipe (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .i_push_valid (w_push_valid),
    .i_push_tag   (w_owner),
    .o_read_valid (Read_valid),
    .o_busy       (w_pipe_busy)
  );

  assign Grant = r_grant;
  assign Busy  = (|r_grant) | w_pipe_busy;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: inputs change 1ns after each rising edge,
// outputs are checked on the falling edge.
module tb_sram_arbiter;

  logic             Clock;
  logic             Resetn;
  logic [3:0]       Req;
  logic [3:0][17:0] Req_address;
  logic [3:0][15:0] Req_write_data;
  logic [3:0]       Req_we_n;
  logic [3:0]       Grant;
  logic [3:0]       Read_valid;
  logic [17:0]      SRAM_address;
  logic [15:0]      SRAM_write_data;
  logic             SRAM_we_n;
  logic             Busy;

  int n_total;
  int n_bad;

  sram_arbiter #(
    .READ_LATENCY (3),
    .MAX_HOLD     (16'd8)
  ) dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .Req             (Req),
    .Req_address     (Req_address),
    .Req_write_data  (Req_write_data),
    .Req_we_n        (Req_we_n),
    .Grant           (Grant),
    .Read_valid      (Read_valid),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .Busy            (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic go();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    @(negedge Clock);
  endtask

  initial begin
    n_total        = 0;
    n_bad          = 0;
    Resetn         = 1'b0;
    Req            = '0;
    Req_we_n       = '1;
    Req_address    = '0;
    Req_write_data = '0;

    settle();
    check_eq("rst_grant", 32'(Grant), 32'h0);
    check_eq("rst_rv", 32'(Read_valid), 32'h0);
    check_eq("rst_busy", 32'(Busy), 32'h0);
    check_eq("rst_we_n", 32'(SRAM_we_n), 32'h1);
    check_eq("rst_addr", 32'(SRAM_address), 32'h0);
    go(); Resetn = 1'b1; settle();

    // UART single read, released on the same cycle it is granted
    go(); Req = 4'b0001; Req_address[0] = 18'h00010; settle();
    check_eq("t1_c0_grant", 32'(Grant), 32'h0);
    go(); Req = 4'b0000; settle();
    check_eq("t1_c1_grant", 32'(Grant), 32'h1);
    check_eq("t1_c1_addr", 32'(SRAM_address), 32'h10);
    check_eq("t1_c1_we_n", 32'(SRAM_we_n), 32'h1);
    check_eq("t1_c1_rv", 32'(Read_valid), 32'h0);
    go(); settle();
    check_eq("t1_c2_grant", 32'(Grant), 32'h0);
    check_eq("t1_c2_rv", 32'(Read_valid), 32'h0);
    go(); settle();
    check_eq("t1_c3_rv", 32'(Read_valid), 32'h0);
    check_eq("t1_c3_busy", 32'(Busy), 32'h1);
    go(); settle();
    check_eq("t1_c4_rv", 32'(Read_valid), 32'h1);
    check_eq("t1_c4_grant", 32'(Grant), 32'h0);
    go(); settle();
    check_eq("t1_c5_rv", 32'(Read_valid), 32'h0);
    check_eq("t1_c5_busy", 32'(Busy), 32'h0);

    // All four request at once; priority order with turnaround cycles
    Req_we_n          = 4'b0000;
    Req_address[0]    = 18'h00100;
    Req_address[1]    = 18'h00200;
    Req_address[2]    = 18'h00300;
    Req_address[3]    = 18'h3FFFF;
    Req_write_data[3] = 16'h5A5A;
    go(); Req = 4'b1111; settle();
    check_eq("t2_c0_grant", 32'(Grant), 32'h0);
    go(); Req = 4'b0111; settle();
    check_eq("t2_c1_grant", 32'(Grant), 32'h8);
    check_eq("t2_c1_addr", 32'(SRAM_address), 32'h3FFFF);
    check_eq("t2_c1_wdata", 32'(SRAM_write_data), 32'h5A5A);
    check_eq("t2_c1_we_n", 32'(SRAM_we_n), 32'h0);
    go(); settle();
    check_eq("t2_turn_grant", 32'(Grant), 32'h0);
    check_eq("t2_turn_we_n", 32'(SRAM_we_n), 32'h1);
    check_eq("t2_turn_addr", 32'(SRAM_address), 32'h0);
    go(); Req = 4'b0110; settle();
    check_eq("t2_c3_grant", 32'(Grant), 32'h1);
    check_eq("t2_c3_addr", 32'(SRAM_address), 32'h100);
    go(); settle();
    check_eq("t2_c4_grant", 32'(Grant), 32'h0);
    go(); Req = 4'b0000; settle();
    check_eq("t2_c5_grant", 32'(Grant), 32'h2);
    check_eq("t2_c5_addr", 32'(SRAM_address), 32'h200);
    go(); settle();
    check_eq("t2_c6_grant", 32'(Grant), 32'h0);
    go(); settle();
    check_eq("t2_c7_busy", 32'(Busy), 32'h0);

    // Hold limit of 8: M1 is forced off after 8 owned cycles, VGA follows
    go(); Req = 4'b0010; settle();
    for (int k = 1; k <= 8; k++) begin
      go();
      if (k == 2) Req = 4'b1010;
      settle();
      check_eq($sformatf("t3_own%0d_grant", k), 32'(Grant), 32'h2);
    end
    go(); settle();
    check_eq("t3_turn_grant", 32'(Grant), 32'h0);
    go(); Req = 4'b0000; settle();
    check_eq("t3_vga_grant", 32'(Grant), 32'h8);
    go(); settle();
    check_eq("t3_end_grant", 32'(Grant), 32'h0);
    go(); settle();

    // M2 five-cycle write burst produces no read pulses
    Req_we_n          = 4'b1011;
    Req_write_data[2] = 16'hABCD;
    go(); Req = 4'b0100; settle();
    for (int k = 1; k <= 5; k++) begin
      go();
      if (k == 5) Req = 4'b0000;
      settle();
      check_eq($sformatf("t4_w%0d_we_n", k), 32'(SRAM_we_n), 32'h0);
      check_eq($sformatf("t4_w%0d_wdata", k), 32'(SRAM_write_data), 32'hABCD);
      check_eq($sformatf("t4_w%0d_rv", k), 32'(Read_valid), 32'h0);
    end
    for (int k = 6; k <= 9; k++) begin
      go(); settle();
      check_eq($sformatf("t4_p%0d_we_n", k), 32'(SRAM_we_n), 32'h1);
      check_eq($sformatf("t4_p%0d_rv", k), 32'(Read_valid), 32'h0);
    end

    // Reset during M1 ownership with two reads in flight
    Req_we_n = 4'b1111;
    go(); Req = 4'b0010; settle();
    go(); settle();
    check_eq("t5_c1_grant", 32'(Grant), 32'h2);
    go(); settle();
    check_eq("t5_c2_grant", 32'(Grant), 32'h2);
    check_eq("t5_c2_busy", 32'(Busy), 32'h1);
    go(); Resetn = 1'b0; Req = 4'b0000; #1;
    check_eq("t5_rst_grant", 32'(Grant), 32'h0);
    check_eq("t5_rst_busy", 32'(Busy), 32'h0);
    settle();
    go(); Resetn = 1'b1; settle();
    for (int k = 0; k < 6; k++) begin
      go(); settle();
      check_eq($sformatf("t5_after%0d_rv", k), 32'(Read_valid), 32'h0);
      check_eq($sformatf("t5_after%0d_grant", k), 32'(Grant), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
